// File: rtl/select_encode_seq.sv
// Register-index selector and operand-fetch sequencer feeding the Rin/Rout decoders.
// Optional write-back step (ra after rc) is enabled by defining SEL_RA_WB_EN.
module select_encode_seq #(
   parameter int DATA_W = 32,
   parameter int C_MSB  = 18
) (
   input  logic              in_clk,
   input  logic              in_reset,
   input  logic [DATA_W-1:0] in_bus,
   input  logic              in_ir_load,
   input  logic              in_gra,
   input  logic              in_grb,
   input  logic              in_grc,
   input  logic              in_rin,
   input  logic              in_rout,
   input  logic              in_baout,
   input  logic              in_seq_start,
   output logic [3:0]        out_sel,
   output logic              out_in_en,
   output logic              out_out_en,
   output logic              out_r0_zero,
   output logic [DATA_W-1:0] out_c_sext,
   output logic [DATA_W-1:0] out_ir,
   output logic              out_busy,
   output logic              out_done
);

   typedef enum logic [2:0] {
      IDLE,
      RB,
      RC,
`ifdef SEL_RA_WB_EN
      WB,
`endif
      DONE
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [DATA_W-1:0] ir_reg;

   logic [3:0] ra_field;
   logic [3:0] rb_field;
   logic [3:0] rc_field;

   assign ra_field = ir_reg[26:23];
   assign rb_field = ir_reg[22:19];
   assign rc_field = ir_reg[18:15];

   // IR is frozen for the whole sequence so every fetch step sees one instruction.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         state_reg <= IDLE;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && in_ir_load) begin
            ir_reg <= in_bus;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      out_sel    = 4'd0;
      out_in_en  = 1'b0;
      out_out_en = 1'b0;
      out_done   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_seq_start) begin
               state_next = RB;
            end
            if (in_gra) begin
               out_sel = ra_field;
            end else if (in_grb) begin
               out_sel = rb_field;
            end else if (in_grc) begin
               out_sel = rc_field;
            end
            out_in_en  = in_rin;
            out_out_en = in_rout | in_baout;
         end
         RB: begin
            out_sel    = rb_field;
            out_out_en = 1'b1;
            state_next = RC;
         end
         RC: begin
            out_sel    = rc_field;
            out_out_en = 1'b1;
`ifdef SEL_RA_WB_EN
            state_next = WB;
`else
            state_next = DONE;
`endif
         end
`ifdef SEL_RA_WB_EN
         WB: begin
            out_sel    = ra_field;
            out_in_en  = 1'b1;
            state_next = DONE;
         end
`endif
         DONE: begin
            out_done   = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign out_r0_zero = in_baout & out_out_en & (out_sel == 4'd0);
   assign out_c_sext  = {{(DATA_W - 1 - C_MSB){ir_reg[C_MSB]}}, ir_reg[C_MSB:0]};
   assign out_ir      = ir_reg;
   assign out_busy    = (state_reg != IDLE);

endmodule
